// File: rtl/lemming_dig_arbiter.sv
// lemming_dig_arbiter: round-robin arbiter handing out single-cycle dig grants from a shared skill pool
module lemming_dig_arbiter #(
    parameter int N           = 4,
    parameter int CW          = 4,
    parameter int INIT_SKILLS = 3,
    parameter int COOLDOWN    = 2
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  walking,
    input  logic          refill,
    input  logic [CW-1:0] refill_count,
    output logic [N-1:0]  dig,
    output logic [CW-1:0] pool,
    output logic          empty,
    output logic          busy
);
    localparam int PW = $clog2(N);
    localparam int KW = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;

    typedef enum logic [1:0] {IDLE, COOL, EMPTY} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [KW-1:0] cnt;
    logic          hit;
    logic          grant;
    logic [N-1:0]  eligible;
    logic [CW:0]   sum;
    logic [CW-1:0] pool_nxt;

    assign eligible = req & walking;
    assign grant    = state == IDLE && hit && pool != '0;
    assign empty    = pool == '0;
    assign busy     = state == COOL;

    // first eligible lemming at or after the round-robin pointer, wrapping
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (!hit && eligible[(int'(ptr) + i) % N]) begin
                hit = 1'b1;
                win = PW'((int'(ptr) + i) % N);
            end
        end
    end

    // pool after this edge: minus a grant, plus a refill, clamped at all-ones
    always_comb begin
        sum      = {1'b0, pool} + (refill ? {1'b0, refill_count} : '0) - {{CW{1'b0}}, grant};
        pool_nxt = sum[CW] ? '1 : sum[CW-1:0];
    end

    // grant/cooldown/empty sequencing with registered dig pulse and pool
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= INIT_SKILLS == 0 ? EMPTY : IDLE;
            dig   <= '0;
            pool  <= CW'(INIT_SKILLS);
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            dig  <= '0;
            pool <= pool_nxt;
            case (state)
                IDLE: begin
                    if (pool == '0) begin
                        state <= EMPTY;
                    end else if (hit) begin
                        dig <= N'(1) << win;
                        ptr <= win == PW'(N - 1) ? '0 : win + 1'b1;
                        if (COOLDOWN != 0) begin
                            state <= COOL;
                            cnt   <= KW'(COOLDOWN - 1);
                        end
                    end
                end
                COOL: begin
                    if (cnt == '0) state <= pool == '0 ? EMPTY : IDLE;
                    else cnt <= cnt - 1'b1;
                end
                default: state <= pool == '0 ? EMPTY : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// tb_lemming_dig_arbiter: scoreboard bench driving a COOLDOWN=2 and a COOLDOWN=0 arbiter side by side
module tb_lemming_dig_arbiter;
    typedef struct {
        int pool;
        int ptr;
        int cool;
        bit emp;
    } mst_t;

    typedef struct {
        logic [3:0] dig;
        logic [3:0] pool;
        logic       busy;
        logic       empty;
    } exp_t;

    logic       clk = 1'b0;
    logic       areset_n;
    logic [3:0] req = '0;
    logic [3:0] walking = '0;
    logic       refill = 1'b0;
    logic [3:0] refill_count = '0;
    logic [3:0] dig0, pool0, dig1, pool1;
    logic       empty0, busy0, empty1, busy1;

    int   tests = 0;
    int   fails = 0;
    mst_t m0, m1;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    lemming_dig_arbiter #(.N(4), .CW(4), .INIT_SKILLS(3), .COOLDOWN(2)) u0 (
        .clk(clk), .areset_n(areset_n), .req(req), .walking(walking),
        .refill(refill), .refill_count(refill_count),
        .dig(dig0), .pool(pool0), .empty(empty0), .busy(busy0)
    );

    lemming_dig_arbiter #(.N(4), .CW(4), .INIT_SKILLS(3), .COOLDOWN(0)) u1 (
        .clk(clk), .areset_n(areset_n), .req(req), .walking(walking),
        .refill(refill), .refill_count(refill_count),
        .dig(dig1), .pool(pool1), .empty(empty1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // One clock edge of the arbiter as described by its rules: cooldown counts busy
    // cycles, emp marks the no-grant wait, a grant takes the first eligible from ptr.
    function automatic mst_t step(input mst_t s, input int cd, input logic [3:0] el,
                                  input bit rf, input int rc, output logic [3:0] g);
        mst_t n = s;
        int   p;
        int   w = 0;
        bit   f = 0;
        g = '0;
        if (s.cool > 0) begin
            n.cool = s.cool - 1;
            if (n.cool == 0) n.emp = (s.pool == 0);
        end else if (s.emp) begin
            n.emp = (s.pool == 0);
        end else if (s.pool == 0) begin
            n.emp = 1;
        end else if (el != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (!f && el[(s.ptr + i) % 4]) begin
                    f = 1;
                    w = (s.ptr + i) % 4;
                end
            end
            g[w]   = 1'b1;
            n.ptr  = (w + 1) % 4;
            n.cool = cd;
        end
        p = s.pool - (g != 0 ? 1 : 0) + (rf ? rc : 0);
        n.pool = p > 15 ? 15 : p;
        return n;
    endfunction

    task automatic cycle(input logic [3:0] r, input logic [3:0] w, input bit rf, input int rc);
        logic [3:0] g;
        req          = r;
        walking      = w;
        refill       = rf;
        refill_count = 4'(rc);
        m0 = step(m0, 2, r & w, rf, rc, g);
        q0.push_back('{g, 4'(m0.pool), m0.cool > 0, m0.pool == 0});
        m1 = step(m1, 0, r & w, rf, rc, g);
        q1.push_back('{g, 4'(m1.pool), m1.cool > 0, m1.pool == 0});
        @(negedge clk);
    endtask

    task automatic do_rst();
        areset_n     = 1'b0;
        req          = '0;
        walking      = '0;
        refill       = 1'b0;
        refill_count = '0;
        #1;
        chk("rst_dig0", dig0, 0);
        chk("rst_pool0", pool0, 3);
        chk("rst_busy0", busy0, 0);
        chk("rst_empty0", empty0, 0);
        chk("rst_dig1", dig1, 0);
        chk("rst_pool1", pool1, 3);
        chk("rst_busy1", busy1, 0);
        chk("rst_empty1", empty1, 0);
        m0 = '{3, 0, 0, 0};
        m1 = '{3, 0, 0, 0};
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("dig0", dig0, e.dig);
                chk("pool0", pool0, e.pool);
                chk("busy0", busy0, e.busy);
                chk("empty0", empty0, e.empty);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("dig1", dig1, e.dig);
                chk("pool1", pool1, e.pool);
                chk("busy1", busy1, e.busy);
                chk("empty1", empty1, e.empty);
            end
        end
    end

    initial begin
        areset_n = 1'b1;
        #1;
        do_rst();
        cycle(4'b0100, 4'b1111, 0, 0);
        repeat (4) cycle(4'b0000, 4'b1111, 0, 0);
        do_rst();
        repeat (12) cycle(4'b1111, 4'b1111, 0, 0);
        do_rst();
        repeat (8) cycle(4'b0011, 4'b0010, 0, 0);
        repeat (2) cycle(4'b0000, 4'b1111, 0, 0);
        cycle(4'b0000, 4'b1111, 1, 2);
        repeat (4) cycle(4'b0100, 4'b1111, 0, 0);
        cycle(4'b0100, 4'b1111, 1, 15);
        repeat (3) cycle(4'b0000, 4'b0000, 0, 0);
        cycle(4'b0001, 4'b1111, 0, 0);
        do_rst();
        repeat (800) begin
            if ($urandom_range(0, 99) == 0) do_rst();
            else cycle(4'($urandom), 4'($urandom | $urandom), $urandom_range(0, 7) == 0,
                       int'($urandom_range(0, 15)));
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
